crossbar_nxm: RTL



---
 rtl/crossbar_nxm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/crossbar_nxm.sv
// crossbar_nxm: N-master x M-slave req/ack crossbar with one arbiter and grant FSM per slave port.
// Define CROSSBAR_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module crossbar_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          master_req,
    input  logic [N_MASTERS-1:0]          master_cmd,
    input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
    output logic [N_MASTERS-1:0]          master_ack,
    output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
    output logic [N_SLAVES-1:0]           slave_req,
    output logic [N_SLAVES-1:0]           slave_cmd,
    output logic [N_SLAVES*ADDR_W-1:0]    slave_addr,
    output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
    input  logic [N_SLAVES-1:0]           slave_ack,
    input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata
);
    localparam int MW = $clog2(N_MASTERS);
    localparam int SW = $clog2(N_SLAVES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [N_MASTERS-1:0]        ack_by_slave   [N_SLAVES];
    logic [N_MASTERS*DATA_W-1:0] rdata_by_slave [N_SLAVES];

    for (genvar s = 0; s < N_SLAVES; s++) begin : g_slave
        logic [1:0]                  state;
        logic [MW-1:0]               gnt_idx;
        logic [MW-1:0]               winner;
        logic [N_MASTERS-1:0]        hit;
        logic                        in_grant;
        logic                        sel_cmd;
        logic [ADDR_W-1:0]           sel_addr;
        logic [DATA_W-1:0]           sel_wdata;
        logic [N_MASTERS-1:0]        ack_local;
        logic [N_MASTERS*DATA_W-1:0] rdata_local;

        // Masters currently requesting and whose top address bits select this slave
        always_comb begin
            hit = '0;
            for (int m = 0; m < N_MASTERS; m++)
                hit[m] = master_req[m] && (master_addr[m*ADDR_W + ADDR_W-1 -: SW] == SW'(s));
        end

`ifdef CROSSBAR_RR_ARB_EN
        logic [MW-1:0] last_gnt;
        logic          found;
        int            idx;

        always_comb begin
            winner = '0;
            found  = 1'b0;
            idx    = 0;
            for (int k = 0; k < N_MASTERS; k++) begin
                idx = int'(last_gnt) + 1 + k;
                if (idx >= N_MASTERS)
                    idx = idx - N_MASTERS;
                if (!found && hit[idx]) begin
                    found  = 1'b1;
                    winner = MW'(idx);
                end
            end
        end

        // Pointer moves only when the slave actually takes the transfer
        always_ff @(posedge clk) begin
            if (!rst_n)
                last_gnt <= MW'(N_MASTERS-1);
            else if (in_grant && slave_ack[s])
                last_gnt <= gnt_idx;
        end
`else
        always_comb begin
            winner = '0;
            for (int k = N_MASTERS-1; k >= 0; k--)
                if (hit[k])
                    winner = MW'(k);
        end
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state   <= IDLE;
                gnt_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (|hit) begin
                            gnt_idx <= winner;
                            state   <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (slave_ack[s])
                            state <= sel_cmd ? IDLE : RDATA;
                    end
                    RDATA:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        assign in_grant = (state == GRANT);

        always_comb begin
            sel_cmd   = master_cmd[gnt_idx];
            sel_addr  = master_addr[gnt_idx*ADDR_W +: ADDR_W];
            sel_wdata = master_wdata[gnt_idx*DATA_W +: DATA_W];
        end

        assign slave_req[s]                    = in_grant;
        assign slave_cmd[s]                    = in_grant & sel_cmd;
        assign slave_addr[s*ADDR_W +: ADDR_W]  = in_grant ? sel_addr : '0;
        assign slave_wdata[s*DATA_W +: DATA_W] = in_grant ? sel_wdata : '0;

        // Return paths stay zero except toward the granted master
        always_comb begin
            ack_local   = '0;
            rdata_local = '0;
            if (in_grant)
                ack_local[gnt_idx] = slave_ack[s];
            if (state == RDATA)
                rdata_local[gnt_idx*DATA_W +: DATA_W] = slave_rdata[s*DATA_W +: DATA_W];
        end

        assign ack_by_slave[s]   = ack_local;
        assign rdata_by_slave[s] = rdata_local;
    end

    always_comb begin
        master_ack   = '0;
        master_rdata = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            master_ack   = master_ack | ack_by_slave[j];
            master_rdata = master_rdata | rdata_by_slave[j];
        end
    end

endmodule
